// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/redirect sequencer.
//   state_e      : sequencer state (run, waiting on data memory, one-cycle trap)
//   REDIR_*      : encodings of redirect_sel
//   REG_X0       : index of the hard-wired zero register
package pipe_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StTrap    = 2'd2
    } state_e;

    localparam logic [1:0] REDIR_BR    = 2'd0;
    localparam logic [1:0] REDIR_MTVEC = 2'd1;
    localparam logic [1:0] REDIR_MEPC  = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/acknowledge handshake.
//   dmem_req : access requested (sequencer -> memory)
//   dmem_ack : access completes this cycle (memory -> sequencer)
// master = sequencer side, slave = memory side.
interface pipe_hazard_ctrl_if;

    logic dmem_req;
    logic dmem_ack;

    modport master (output dmem_req, input dmem_ack);
    modport slave  (input dmem_req, output dmem_ack);

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator.
//   rd_en_mem_i, rf_en_mem_i, rd_mem_i : load in MEM and its destination
//   rs1_ex_i, rs2_ex_i                 : EX source registers
//   hazard_o                           : EX needs the value the MEM load returns
module pipe_hazard_detect
    import pipe_pkg::*;
(
    input  logic       rd_en_mem_i,
    input  logic       rf_en_mem_i,
    input  logic [4:0] rd_mem_i,
    input  logic [4:0] rs1_ex_i,
    input  logic [4:0] rs2_ex_i,
    output logic       hazard_o
);

    assign hazard_o = rd_en_mem_i & rf_en_mem_i & (rd_mem_i != REG_X0) &
                      ((rd_mem_i == rs1_ex_i) | (rd_mem_i == rs2_ex_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the IF / EX / MEM-WB pipeline.
// Inputs : br_taken_ex, rs1_ex, rs2_ex, rd_mem, rf_en_mem, rd_en_mem, wr_en_mem,
//          is_mret_mem, irq_pending, mie_global, dmem.dmem_ack
// Outputs: dmem.dmem_req, stall_if, mem_hold, flush_if_ex, flush_ex_mem, pc_redirect,
//          redirect_sel, trap_take, bus_err, stall_cnt (saturating stall-cycle count)
// Priority in RUN: memory wait > trap > mret > load-use > branch.
// Optional macro PIPE_HAZARD_CTRL_MEM_TIMEOUT_EN adds a MEM_WAIT timeout that raises
// bus_err and traps; without it bus_err is 0 and MEM_WAIT waits indefinitely.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 br_taken_ex,
    input  logic [4:0]           rs1_ex,
    input  logic [4:0]           rs2_ex,
    input  logic [4:0]           rd_mem,
    input  logic                 rf_en_mem,
    input  logic                 rd_en_mem,
    input  logic                 wr_en_mem,
    input  logic                 is_mret_mem,
    input  logic                 irq_pending,
    input  logic                 mie_global,
    pipe_hazard_ctrl_if.master   dmem,
    output logic                 stall_if,
    output logic                 mem_hold,
    output logic                 flush_if_ex,
    output logic                 flush_ex_mem,
    output logic                 pc_redirect,
    output logic [1:0]           redirect_sel,
    output logic                 trap_take,
    output logic                 bus_err,
    output logic [CNT_W-1:0]     stall_cnt
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               ack, mem_op, trap_cond, load_use;
    logic               dmem_req_c, bus_err_c;
    logic               tmo_hit;

    assign ack       = dmem.dmem_ack;
    assign mem_op    = rd_en_mem | wr_en_mem;
    assign trap_cond = irq_pending & mie_global & ~mem_op & ~is_mret_mem;

    pipe_hazard_detect u_hazard_detect (
        .rd_en_mem_i (rd_en_mem),
        .rf_en_mem_i (rf_en_mem),
        .rd_mem_i    (rd_mem),
        .rs1_ex_i    (rs1_ex),
        .rs2_ex_i    (rs2_ex),
        .hazard_o    (load_use)
    );

`ifdef PIPE_HAZARD_CTRL_MEM_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmoW-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    // Counts un-acked MEM_WAIT cycles; anything else (ack, timeout, other state) clears it.
    always_comb begin
        tmo_d = '0;
        if (rst_n && (state_q == StMemWait) && !ack && !tmo_hit) begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign tmo_hit               = 1'b0;
    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d      = state_q;
        dmem_req_c   = 1'b0;
        stall_if     = 1'b0;
        mem_hold     = 1'b0;
        flush_if_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        pc_redirect  = 1'b0;
        redirect_sel = REDIR_BR;
        trap_take    = 1'b0;
        bus_err_c    = 1'b0;

        // Outputs are forced low while reset is held so an abandoned access drops at once.
        if (rst_n) begin
            unique case (state_q)
                StRun: begin
                    dmem_req_c = mem_op;
                    if (mem_op && !ack) begin
                        stall_if = 1'b1;
                        mem_hold = 1'b1;
                        state_d  = StMemWait;
                    end else if (trap_cond) begin
                        // Coincident branch is dropped; TRAP flushes everything next cycle.
                        state_d = StTrap;
                    end else if (is_mret_mem) begin
                        pc_redirect  = 1'b1;
                        redirect_sel = REDIR_MEPC;
                        flush_if_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else if (load_use) begin
                        // Branch deferred: EX is held and re-evaluates next cycle.
                        stall_if     = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else if (br_taken_ex) begin
                        pc_redirect = 1'b1;
                        flush_if_ex = 1'b1;
                    end
                end
                StMemWait: begin
                    dmem_req_c = 1'b1;
                    if (ack) begin
                        // Ack cycle behaves like a zero-wait access: pending bubble or branch.
                        state_d = StRun;
                        if (load_use) begin
                            stall_if     = 1'b1;
                            flush_ex_mem = 1'b1;
                        end else if (br_taken_ex) begin
                            pc_redirect = 1'b1;
                            flush_if_ex = 1'b1;
                        end
                    end else begin
                        stall_if = 1'b1;
                        mem_hold = 1'b1;
                        if (tmo_hit) begin
                            bus_err_c = 1'b1;
                            state_d   = StTrap;
                        end
                    end
                end
                StTrap: begin
                    trap_take    = 1'b1;
                    pc_redirect  = 1'b1;
                    redirect_sel = REDIR_MTVEC;
                    flush_if_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    state_d      = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem.dmem_req = dmem_req_c;
    assign bus_err       = bus_err_c;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed steps followed by random traffic,
// each cycle compared against a flag-based reference model of the sequencing rules.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int unsigned Tmo  = 8;
    localparam int unsigned CntW = 6;
    localparam int unsigned StallMax = (1 << CntW) - 1;
`ifdef PIPE_HAZARD_CTRL_MEM_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic            clk, rst_n;
    logic            br_taken_ex, rf_en_mem, rd_en_mem, wr_en_mem;
    logic            is_mret_mem, irq_pending, mie_global;
    logic [4:0]      rs1_ex, rs2_ex, rd_mem;
    logic            stall_if, mem_hold, flush_if_ex, flush_ex_mem, pc_redirect;
    logic            trap_take, bus_err;
    logic [1:0]      redirect_sel;
    logic [CntW-1:0] stall_cnt;

    pipe_hazard_ctrl_if u_if ();

    pipe_hazard_ctrl #(
        .TIMEOUT_CYCLES (Tmo),
        .CNT_W          (CntW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_taken_ex  (br_taken_ex),
        .rs1_ex       (rs1_ex),
        .rs2_ex       (rs2_ex),
        .rd_mem       (rd_mem),
        .rf_en_mem    (rf_en_mem),
        .rd_en_mem    (rd_en_mem),
        .wr_en_mem    (wr_en_mem),
        .is_mret_mem  (is_mret_mem),
        .irq_pending  (irq_pending),
        .mie_global   (mie_global),
        .dmem         (u_if),
        .stall_if     (stall_if),
        .mem_hold     (mem_hold),
        .flush_if_ex  (flush_if_ex),
        .flush_ex_mem (flush_ex_mem),
        .pc_redirect  (pc_redirect),
        .redirect_sel (redirect_sel),
        .trap_take    (trap_take),
        .bus_err      (bus_err),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an access is outstanding, a trap is due, wait length, stall count.
    bit          m_pend;
    bit          m_trap;
    int unsigned m_wait;
    int unsigned m_stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend   = 1'b0;
        m_trap   = 1'b0;
        m_wait   = 0;
        m_stalls = 0;
    endtask

    task automatic idle_inputs();
        br_taken_ex = 1'b0; rf_en_mem = 1'b0; rd_en_mem = 1'b0; wr_en_mem = 1'b0;
        is_mret_mem = 1'b0; irq_pending = 1'b0; mie_global = 1'b0;
        rs1_ex = 5'd0; rs2_ex = 5'd0; rd_mem = 5'd0; u_if.dmem_ack = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next one.
    task automatic step(input string tag);
        logic        e_req, e_stall, e_hold, e_fie, e_fem, e_redir, e_trap, e_berr;
        logic [1:0]  e_sel;
        bit          n_pend, n_trap, mem_op, lu, ack;
        int unsigned n_wait;
        e_req = 0; e_stall = 0; e_hold = 0; e_fie = 0; e_fem = 0;
        e_redir = 0; e_trap = 0; e_berr = 0; e_sel = REDIR_BR;
        n_pend = m_pend; n_trap = 1'b0; n_wait = m_wait;
        ack    = u_if.dmem_ack;
        mem_op = rd_en_mem | wr_en_mem;
        lu     = rd_en_mem && rf_en_mem && (rd_mem != 5'd0) &&
                 ((rd_mem == rs1_ex) || (rd_mem == rs2_ex));
        if (m_trap) begin
            e_trap = 1; e_redir = 1; e_sel = REDIR_MTVEC; e_fie = 1; e_fem = 1;
        end else if (m_pend) begin
            e_req = 1;
            if (ack) begin
                n_pend = 0; n_wait = 0;
                if (lu) begin e_stall = 1; e_fem = 1; end
                else if (br_taken_ex) begin e_redir = 1; e_fie = 1; end
            end else begin
                e_stall = 1; e_hold = 1;
                if (TmoEn && (m_wait == Tmo - 1)) begin
                    e_berr = 1; n_trap = 1; n_pend = 0; n_wait = 0;
                end else begin
                    n_wait = m_wait + 1;
                end
            end
        end else begin
            e_req = mem_op;
            if (mem_op && !ack) begin
                e_stall = 1; e_hold = 1; n_pend = 1; n_wait = 0;
            end else if (irq_pending && mie_global && !mem_op && !is_mret_mem) begin
                n_trap = 1;
            end else if (is_mret_mem) begin
                e_redir = 1; e_sel = REDIR_MEPC; e_fie = 1; e_fem = 1;
            end else if (lu) begin
                e_stall = 1; e_fem = 1;
            end else if (br_taken_ex) begin
                e_redir = 1; e_fie = 1;
            end
        end
        #2;
        chk({tag, ".dmem_req"}, 32'(u_if.dmem_req), 32'(e_req));
        chk({tag, ".stall_if"}, 32'(stall_if), 32'(e_stall));
        chk({tag, ".mem_hold"}, 32'(mem_hold), 32'(e_hold));
        chk({tag, ".flush_if_ex"}, 32'(flush_if_ex), 32'(e_fie));
        chk({tag, ".flush_ex_mem"}, 32'(flush_ex_mem), 32'(e_fem));
        chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(e_redir));
        chk({tag, ".redirect_sel"}, 32'(redirect_sel), 32'(e_sel));
        chk({tag, ".trap_take"}, 32'(trap_take), 32'(e_trap));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(e_berr));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), m_stalls);
        @(posedge clk);
        m_pend = n_pend; m_trap = n_trap; m_wait = n_wait;
        if (e_stall && (m_stalls < StallMax)) m_stalls++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rd_en_mem = 1'b1; // outputs must stay low under reset even with a pending access
        #1;
        chk("reset.dmem_req", 32'(u_if.dmem_req), 32'd0);
        chk("reset.stall_if", 32'(stall_if), 32'd0);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");

        // Load x5 used by EX, zero-wait ack: one bubble cycle.
        rd_en_mem = 1; rf_en_mem = 1; rd_mem = 5'd5; rs1_ex = 5'd5; u_if.dmem_ack = 1;
        step("lu0");
        idle_inputs();
        step("lu1");
        chk("lu.stall_cnt", 32'(stall_cnt), 32'd1);

        // Store acked on the fourth request cycle.
        wr_en_mem = 1;
        repeat (3) step("st_wait");
        u_if.dmem_ack = 1;
        step("st_ack");
        idle_inputs();
        step("st_done");
        chk("st.stall_cnt", 32'(stall_cnt), 32'd4);

        // Branch with interrupt: trap wins, branch dropped.
        br_taken_ex = 1; irq_pending = 1; mie_global = 1;
        step("irq_det");
        step("irq_trap");
        idle_inputs();
        step("irq_after");

        // mret with branch.
        is_mret_mem = 1; br_taken_ex = 1;
        step("mret");
        idle_inputs();

        // Load-use behind a waited load: bubble on the ack cycle.
        rd_en_mem = 1; rf_en_mem = 1; rd_mem = 5'd7; rs2_ex = 5'd7; br_taken_ex = 1;
        repeat (2) step("lu_wait");
        u_if.dmem_ack = 1;
        step("lu_ack");
        u_if.dmem_ack = 0; rd_en_mem = 0;
        step("lu_br");
        idle_inputs();

        // Never-acked load: times out only when the optional feature is built in.
        rd_en_mem = 1;
        repeat (12) step("tmo");
        u_if.dmem_ack = 1;
        step("tmo_ack");
        idle_inputs();
        step("tmo_idle");

        // Reset during MEM_WAIT drops the request asynchronously.
        wr_en_mem = 1;
        repeat (2) step("rst_wait");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.dmem_req", 32'(u_if.dmem_req), 32'd0);
        chk("async_rst.stall_if", 32'(stall_if), 32'd0);
        chk("async_rst.mem_hold", 32'(mem_hold), 32'd0);
        chk("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");

        // Random traffic; long enough to drive stall_cnt into saturation.
        for (int i = 0; i < 500; i++) begin
            idle_inputs();
            rd_en_mem   = ($urandom_range(0, 9) < 3);
            wr_en_mem   = !rd_en_mem && ($urandom_range(0, 9) < 2);
            rf_en_mem   = ($urandom_range(0, 3) != 0);
            rd_mem      = 5'($urandom_range(0, 3));
            rs1_ex      = 5'($urandom_range(0, 3));
            rs2_ex      = 5'($urandom_range(0, 3));
            br_taken_ex = ($urandom_range(0, 3) == 0);
            is_mret_mem = !rd_en_mem && !wr_en_mem && ($urandom_range(0, 15) == 0);
            irq_pending = ($urandom_range(0, 7) == 0);
            mie_global  = ($urandom_range(0, 1) == 1);
            u_if.dmem_ack = ($urandom_range(0, 1) == 1);
            step("rand");
        end
        chk("sat.stall_cnt", 32'(stall_cnt), m_stalls);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
